// File: rtl/uart_tx_rr_arbiter_if.sv
// Byte-request and serial-line bundle for uart_tx_rr_arbiter.
// master = byte producers, slave = the arbiter/transmitter.
interface uart_tx_rr_arbiter_if #(
    parameter int NUM_REQ = 2
);
    localparam int IW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]   REQ_VALID;
    logic [8*NUM_REQ-1:0] REQ_DATA;
    logic [NUM_REQ-1:0]   REQ_READY;
    logic                 TXD;
    logic                 BUSY;
    logic [IW-1:0]        GRANT_ID;

    modport master (
        output REQ_VALID, REQ_DATA,
        input  REQ_READY, TXD, BUSY, GRANT_ID
    );

    modport slave (
        input  REQ_VALID, REQ_DATA,
        output REQ_READY, TXD, BUSY, GRANT_ID
    );
endinterface

// File: rtl/uart_tx_rr_arbiter.sv
// Round-robin arbiter sharing one 8N1 UART transmitter between NUM_REQ byte sources.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and stop.
module uart_tx_rr_arbiter #(
    parameter int NUM_REQ      = 2,
    parameter int CLKS_PER_BIT = 434
) (
    input logic FAB_CCC_GL0,
    input logic FAB_RESET,
    uart_tx_rr_arbiter_if.slave link
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t        state_reg, state_next;
    logic [BW-1:0] baud_reg, baud_next;
    logic [2:0]    bit_reg, bit_next;
    logic [7:0]    shift_reg, shift_next;
    logic [IW-1:0] pointer_reg, pointer_next;
    logic [IW-1:0] grant_reg, grant_next;
    logic          txd_reg, txd_next;
    logic          busy_reg, busy_next;
`ifdef UART_TX_PARITY_EN
    logic          parity_reg, parity_next;
`endif

    logic [NUM_REQ-1:0] rot_valid;
    logic [IW-1:0]      rot_idx [NUM_REQ];
    logic [IW-1:0]      pick;
    logic [7:0]         pick_data;
    logic               accept;
    logic               bit_end;
    logic [NUM_REQ-1:0] ready;

    // Requester seen at position gi when scanning upward from the pointer.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rot
            logic [IW:0] sum;
            assign sum = {1'b0, pointer_reg} + (IW+1)'(gi);
            assign rot_idx[gi] = (sum >= (IW+1)'(NUM_REQ)) ?
                                 IW'(sum - (IW+1)'(NUM_REQ)) : sum[IW-1:0];
            assign rot_valid[gi] = link.REQ_VALID[rot_idx[gi]];
        end
    endgenerate

    // Descending scan so the position nearest the pointer wins.
    always_comb begin
        pick = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rot_valid[k]) begin
                pick = rot_idx[k];
            end
        end
    end

    assign accept    = (state_reg == IDLE) && (|rot_valid);
    assign pick_data = link.REQ_DATA[8*pick +: 8];
    assign bit_end   = (baud_reg == BW'(CLKS_PER_BIT - 1));

    always_comb begin
        ready = '0;
        if (accept) begin
            ready[pick] = 1'b1;
        end
    end

    always_comb begin
        state_next   = state_reg;
        baud_next    = baud_reg;
        bit_next     = bit_reg;
        shift_next   = shift_reg;
        pointer_next = pointer_reg;
        grant_next   = grant_reg;
`ifdef UART_TX_PARITY_EN
        parity_next  = parity_reg;
`endif
        if (state_reg != IDLE) begin
            baud_next = bit_end ? '0 : baud_reg + 1'b1;
        end

        case (state_reg)
            IDLE: begin
                baud_next = '0;
                if (accept) begin
                    shift_next   = pick_data;
                    grant_next   = pick;
                    pointer_next = (pick == IW'(NUM_REQ - 1)) ? '0 : pick + 1'b1;
                    bit_next     = '0;
                    state_next   = START;
`ifdef UART_TX_PARITY_EN
                    parity_next  = ^pick_data;
`endif
                end
            end
            START: begin
                if (bit_end) begin
                    bit_next   = '0;
                    state_next = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_reg == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end else begin
                        bit_next   = bit_reg + 3'd1;
                        shift_next = shift_reg >> 1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_next = STOP;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        // TXD and BUSY are registered from the next state so they line up with it.
        txd_next = 1'b1;
        case (state_next)
            START:   txd_next = 1'b0;
            DATA:    txd_next = shift_next[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  txd_next = parity_next;
`endif
            default: txd_next = 1'b1;
        endcase
        busy_next = (state_next != IDLE);
    end

    always_ff @(posedge FAB_CCC_GL0 or posedge FAB_RESET) begin
        if (FAB_RESET) begin
            state_reg   <= IDLE;
            baud_reg    <= '0;
            bit_reg     <= '0;
            shift_reg   <= '0;
            pointer_reg <= '0;
            grant_reg   <= '0;
            txd_reg     <= 1'b1;
            busy_reg    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_reg  <= 1'b0;
`endif
        end else begin
            state_reg   <= state_next;
            baud_reg    <= baud_next;
            bit_reg     <= bit_next;
            shift_reg   <= shift_next;
            pointer_reg <= pointer_next;
            grant_reg   <= grant_next;
            txd_reg     <= txd_next;
            busy_reg    <= busy_next;
`ifdef UART_TX_PARITY_EN
            parity_reg  <= parity_next;
`endif
        end
    end

    assign link.REQ_READY = ready;
    assign link.TXD       = txd_reg;
    assign link.BUSY      = busy_reg;
    assign link.GRANT_ID  = grant_reg;
endmodule

// File: tb/tb_uart_tx_rr_arbiter.sv
// Bench for uart_tx_rr_arbiter: expected frames are queued when a byte is offered
// and popped when the DUT starts a frame, then checked bit by bit.
module tb_uart_tx_rr_arbiter;
    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int SLOTS = 11;
`else
    localparam int SLOTS = 10;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_tx_rr_arbiter_if #(.NUM_REQ(2)) link2 ();
    uart_tx_rr_arbiter_if #(.NUM_REQ(3)) link3 ();

    uart_tx_rr_arbiter #(.NUM_REQ(2), .CLKS_PER_BIT(CPB)) dut2 (
        .FAB_CCC_GL0(clk),
        .FAB_RESET  (rst),
        .link       (link2.slave)
    );

    uart_tx_rr_arbiter #(.NUM_REQ(3), .CLKS_PER_BIT(CPB)) dut3 (
        .FAB_CCC_GL0(clk),
        .FAB_RESET  (rst),
        .link       (link3.slave)
    );

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   acc_q[$];
    int   cycle_cnt     = 0;
    int   checks_total  = 0;
    int   checks_passed = 0;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_total++;
        if (obs === exp) begin
            checks_passed++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        cycle_cnt++;
        if (|(link2.REQ_VALID & link2.REQ_READY)) begin
            acc_q.push_back(cycle_cnt);
        end
    end

    task automatic push_exp(input int id, input logic [7:0] data);
        exp_t e;
        e.id   = 2'(id);
        e.data = data;
        exp_q.push_back(e);
    endtask

    // Offer one byte on requester id; returns just after the accepting edge.
    task automatic send_one(input int id, input logic [7:0] data);
        int n;
        push_exp(id, data);
        @(posedge clk); #1;
        link2.REQ_DATA[8*id +: 8] = data;
        link2.REQ_VALID[id]       = 1'b1;
        @(negedge clk);
        n = 0;
        while (link2.REQ_READY[id] !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_value("ready_same_cycle", 32'(n), 32'(0));
        check_value("ready_onehot", 32'(link2.REQ_READY), 32'(1 << id));
        @(posedge clk); #1;
        link2.REQ_VALID[id] = 1'b0;
    endtask

    // Waits for the next frame, then checks every cycle of it against the scoreboard.
    task automatic check_frame();
        int   n;
        exp_t e;
        logic bitv;
        @(negedge clk);
        n = 0;
        while (link2.BUSY !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (link2.BUSY !== 1'b1) begin
            check_value("frame_start_timeout", 32'(link2.BUSY), 32'(1));
            return;
        end
        if (exp_q.size() == 0) begin
            check_value("scoreboard_empty", 32'(0), 32'(1));
            return;
        end
        e = exp_q.pop_front();
        $display("frame: grant %0d byte 0x%02h", link2.GRANT_ID, e.data);
        check_value("grant_id", 32'(link2.GRANT_ID), 32'(e.id));
        for (int s = 0; s < SLOTS; s++) begin
            if (s == 0) bitv = 1'b0;
            else if (s <= 8) bitv = e.data[s-1];
            else if (s == SLOTS - 1) bitv = 1'b1;
            else bitv = ^e.data;
            for (int c = 0; c < CPB; c++) begin
                check_value($sformatf("frame_slot%0d", s), 32'({link2.BUSY, link2.TXD}),
                            32'({1'b1, bitv}));
                @(negedge clk);
            end
        end
        check_value("frame_end", 32'({link2.BUSY, link2.TXD}), 32'(2'b01));
    endtask

    task automatic wait_idle3(input string tag);
        int n;
        n = 0;
        while (link3.BUSY !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_value(tag, 32'(link3.BUSY), 32'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        link2.REQ_VALID = '0;
        link2.REQ_DATA  = '0;
        link3.REQ_VALID = '0;
        link3.REQ_DATA  = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check_value("reset_idle", 32'({link2.TXD, link2.BUSY, link2.REQ_READY, link2.GRANT_ID}),
                        32'(5'b10000));
        end

        send_one(0, 8'h41);
        check_frame();
        send_one(1, 8'h5A);
        check_frame();

        // Both held valid: grants alternate starting from requester 0.
        acc_q.delete();
        push_exp(0, 8'hAA);
        push_exp(1, 8'h55);
        push_exp(0, 8'hAA);
        push_exp(1, 8'h55);
        @(posedge clk); #1;
        link2.REQ_DATA  = 16'h55AA;
        link2.REQ_VALID = 2'b11;
        for (int f = 0; f < 4; f++) begin
            check_frame();
        end
        link2.REQ_VALID = '0;
        check_value("accept_count", 32'(acc_q.size() >= 4), 32'(1));
        if (acc_q.size() >= 4) begin
            for (int i = 1; i < 4; i++) begin
                $display("accept spacing %0d: %0d cycles", i, acc_q[i] - acc_q[i-1]);
                check_value("accept_spacing", 32'(acc_q[i] - acc_q[i-1]), 32'(41));
            end
        end

        send_one(1, 8'hC3);
        check_frame();
        send_one(0, 8'h3C);
        check_frame();

        // Three requesters: move the pointer to 2, then offer 0 and 2 together.
        @(posedge clk); #1;
        link3.REQ_DATA  = 24'h33_11_22;
        link3.REQ_VALID = 3'b010;
        @(negedge clk);
        check_value("n3_ready_req1", 32'(link3.REQ_READY), 32'(3'b010));
        @(posedge clk); #1;
        link3.REQ_VALID = '0;
        @(negedge clk);
        check_value("n3_grant1", 32'(link3.GRANT_ID), 32'(1));
        wait_idle3("n3_frame1_done");
        @(posedge clk); #1;
        link3.REQ_VALID = 3'b101;
        @(negedge clk);
        check_value("n3_ready_req2", 32'(link3.REQ_READY), 32'(3'b100));
        @(posedge clk); #1;
        link3.REQ_VALID = '0;
        @(negedge clk);
        check_value("n3_grant2", 32'(link3.GRANT_ID), 32'(2));
        $display("n3: grant %0d after pointer at 2", link3.GRANT_ID);
        wait_idle3("n3_frame2_done");
        link3.REQ_VALID = 3'b011;
        #1;
        check_value("n3_ptr_wrap", 32'(link3.REQ_READY), 32'(3'b001));
        link3.REQ_VALID = '0;

        // Reset in the middle of data bit 3 of 0x0F.
        @(posedge clk); #1;
        link2.REQ_DATA[7:0] = 8'h0F;
        link2.REQ_VALID     = 2'b01;
        @(negedge clk);
        check_value("rst_frame_ready", 32'(link2.REQ_READY), 32'(2'b01));
        @(posedge clk); #1;
        link2.REQ_VALID = '0;
        repeat (18) @(negedge clk);
        check_value("rst_before_bit3", 32'({link2.BUSY, link2.TXD}), 32'(2'b11));
        #2 rst = 1'b1;
        #1;
        check_value("rst_async", 32'({link2.TXD, link2.BUSY, link2.REQ_READY, link2.GRANT_ID}),
                    32'(5'b10000));
        $display("reset mid-frame: TXD %0b BUSY %0b", link2.TXD, link2.BUSY);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check_value("rst_release_idle", 32'({link2.TXD, link2.BUSY}), 32'(2'b10));
        link2.REQ_DATA  = 16'hB7_0F;
        link2.REQ_VALID = 2'b11;
        #1;
        check_value("rst_pointer_zero", 32'(link2.REQ_READY), 32'(2'b01));
        link2.REQ_VALID = '0;
        send_one(1, 8'hB7);
        check_frame();

        send_one(0, 8'h07);
        check_frame();
        send_one(0, 8'h03);
        check_frame();

        check_value("scoreboard_drained", 32'(exp_q.size()), 32'(0));
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end
endmodule

// File: doc/uart_tx_rr_arbiter.md
Name: uart_tx_rr_arbiter

Overview:
- Shares one fabric 8N1 UART transmitter between NUM_REQ byte sources using round-robin arbitration.
- Each requester presents a byte with a valid/ready handshake. The block grants one requester, serializes its byte onto TXD, then re-arbitrates.
- Sits in the fabric between the character/blink logic and the UART TXD pin, so several producers (echo path, status messages) can share one serial line.

Parameters:
- NUM_REQ, 2, number of requesters; legal range 2..8.
- CLKS_PER_BIT, 434, FAB_CCC_GL0 cycles per serial bit (50 MHz / 115200); must be at least 2.

Ports:
- FAB_CCC_GL0  in  1  fabric clock; all state changes on its rising edge.
- FAB_RESET  in  1  asynchronous, active-high reset.
- REQ_VALID  in  NUM_REQ  per-requester byte valid; the requester holds it and REQ_DATA stable until accepted.
- REQ_DATA  in  8*NUM_REQ  requester i's byte is at bits [8i+7:8i].
- REQ_READY  out  NUM_REQ  one-hot accept; byte transfer occurs in a cycle where REQ_VALID[i] and REQ_READY[i] are both 1.
- TXD  out  1  serial output; idle level is 1.
- BUSY  out  1  1 while a frame is on the line (START through STOP).
- GRANT_ID  out  clog2(NUM_REQ)  index of the last granted requester; holds until the next grant.

Behaviour:
- Reset (asynchronous assert, synchronous-to-clock release):
  - TXD=1, BUSY=0, REQ_READY=0, GRANT_ID=0.
  - Priority pointer=0, state=IDLE, bit counter and baud counter=0.
- States: IDLE, START, DATA, STOP.
- IDLE:
  - REQ_READY is combinational from registered state plus REQ_VALID. It is one-hot on the first valid requester found scanning from the pointer upward, modulo NUM_REQ.
  - It is all-zero when no requester is valid or the state is not IDLE.
  - On a handshake to requester g:
    - latch REQ_DATA[g] into the shift register;
    - GRANT_ID<=g;
    - pointer<=(g+1) mod NUM_REQ;
    - state<=START.
- START: TXD=0 for exactly CLKS_PER_BIT cycles.
  - Latency: TXD falls on the clock edge at the end of the accept cycle, i.e. the next cycle.
- DATA: 8 bits, LSB first, each held for CLKS_PER_BIT cycles. The bit counter runs 0..7, then state<=STOP.
- STOP: TXD=1 for CLKS_PER_BIT cycles, then state<=IDLE.
- Frame length is 10*CLKS_PER_BIT cycles. The earliest next accept is the first IDLE cycle, so the minimum accept-to-accept spacing is 10*CLKS_PER_BIT+1 cycles.
- BUSY=1 in START, DATA and STOP; 0 in IDLE. It is registered and aligned with TXD.
- Baud counter counts 0..CLKS_PER_BIT-1, reloads at 0 on every bit boundary, and is held at 0 in IDLE.
- Simultaneous requests: exactly one is granted per frame. With all requesters continuously valid, the grant order is 0,1,..,NUM_REQ-1,0,...
- A requester dropping REQ_VALID before acceptance is a protocol violation. The block simply skips that requester, with no side effects.
- REQ_VALID changes during START, DATA or STOP are ignored; arbitration happens only in IDLE.
- Reset mid-frame: TXD returns to 1 immediately (asynchronous). The frame is abandoned, the pointer goes to 0, and no byte is re-sent.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- When defined: state PARITY is inserted between DATA and STOP.
  - TXD carries the even-parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles.
  - Frame length becomes 11*CLKS_PER_BIT.
- When undefined: no PARITY state; the 8N1 frame is exactly as above.

Test Plan (CLKS_PER_BIT=4, NUM_REQ=2 unless stated):
- Reset, then idle for 20 cycles -> TXD=1, BUSY=0, REQ_READY=00, GRANT_ID=0 throughout.
- Requester 0 valid with 0x41 ->
  - REQ_READY=01 in the same cycle; TXD low starting next cycle for 4 cycles;
  - bits 1,0,0,0,0,0,1,0 at 4 cycles each; then stop 1 for 4 cycles;
  - BUSY high for 40 cycles; GRANT_ID=0.
- Both requesters held valid (0xAA, 0x55) for 4 frames -> grant order 0,1,0,1; GRANT_ID follows; accepts spaced 41 cycles apart.
- After a grant to requester 1, only requester 0 is valid -> requester 0 is granted immediately; NUM_REQ=3 with pointer at 2 and requesters 0 and 2 valid -> requester 2 granted.
- FAB_RESET pulsed during data bit 3 of 0x0F -> TXD=1 and BUSY=0 on assertion; after release, requester 1 valid -> requester 1 is granted and its byte is sent from a clean start bit.
- With UART_TX_PARITY_EN defined, send 0x07 -> parity bit 1 after bit 7, BUSY high for 44 cycles; send 0x03 -> parity bit 0.
